// File: rtl/fsm_datapath.sv
// Sequencer datapath: 16-entry register file, single-cycle ALU, status flags and a
// write-back display tap. Control arrives from an FSM that updates on the falling edge.
module fsm_datapath #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned NREGS = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [7:0]       alu_op,
  input  logic [4:0]       muxA,
  input  logic [4:0]       muxB,
  input  logic [WIDTH-1:0] imm,
  input  logic             imm_control,
  input  logic [NREGS-1:0] regs_en,
  input  logic             buff_en,
  output logic [WIDTH-1:0] bus_out,
  output logic [4:0]       flags,
  output logic [WIDTH-1:0] last_wr
);

  localparam int unsigned IDXW = $clog2(NREGS);
  localparam logic [5:0]  NREGS_W = 6'(NREGS);

  localparam logic [7:0] OP_AND  = 8'h01;
  localparam logic [7:0] OP_OR   = 8'h02;
  localparam logic [7:0] OP_XOR  = 8'h03;
  localparam logic [7:0] OP_LSH  = 8'h04;
  localparam logic [7:0] OP_ADD  = 8'h05;
  localparam logic [7:0] OP_ADDC = 8'h07;
  localparam logic [7:0] OP_RSH  = 8'h08;
  localparam logic [7:0] OP_SUB  = 8'h09;
  localparam logic [7:0] OP_CMP  = 8'h0B;
  localparam logic [7:0] OP_MOV  = 8'h0D;

  // Bit positions within flags = {C, L, F, Z, N}
  localparam int unsigned FC = 4;
  localparam int unsigned FL = 3;
  localparam int unsigned FF = 2;
  localparam int unsigned FZ = 1;
  localparam int unsigned FN = 0;

  logic [WIDTH-1:0] regs_q [NREGS];
  logic [WIDTH-1:0] regs_d [NREGS];
  logic [4:0]       flags_q, flags_d;
  logic [WIDTH-1:0] last_wr_q, last_wr_d;

  logic [WIDTH-1:0] a_c, b_c, result_c;
  logic [WIDTH:0]   sum_c;
  logic             legal_c, wr_ok_c, upd_cf_c, upd_l_c;
  logic             c_c, f_c, l_c;

  // Operand fetch; out-of-range indices read as zero
  always_comb begin
    a_c = '0;
    b_c = '0;
    if ({1'b0, muxA} < NREGS_W) a_c = regs_q[muxA[IDXW-1:0]];
    if (imm_control)                b_c = imm;
    else if ({1'b0, muxB} < NREGS_W) b_c = regs_q[muxB[IDXW-1:0]];
  end

  always_comb begin
    result_c = '0;
    sum_c    = '0;
    legal_c  = 1'b1;
    wr_ok_c  = 1'b1;
    upd_cf_c = 1'b0;
    upd_l_c  = 1'b0;
    c_c      = 1'b0;
    f_c      = 1'b0;
    l_c      = 1'b0;
    case (alu_op)
      OP_AND: result_c = a_c & b_c;
      OP_OR:  result_c = a_c | b_c;
      OP_XOR: result_c = a_c ^ b_c;
      OP_LSH: result_c = a_c << b_c[3:0];
      OP_RSH: result_c = a_c >> b_c[3:0];
      OP_MOV: result_c = b_c;
      OP_ADD, OP_ADDC: begin
        sum_c    = {1'b0, a_c} + {1'b0, b_c};
        if (alu_op == OP_ADDC) sum_c = sum_c + (WIDTH+1)'(flags_q[FC]);
        result_c = sum_c[WIDTH-1:0];
        upd_cf_c = 1'b1;
        c_c      = sum_c[WIDTH];
        f_c      = (a_c[WIDTH-1] == b_c[WIDTH-1]) && (result_c[WIDTH-1] != a_c[WIDTH-1]);
      end
      OP_SUB, OP_CMP: begin
        sum_c    = {1'b0, a_c} - {1'b0, b_c};
        result_c = sum_c[WIDTH-1:0];
        wr_ok_c  = (alu_op == OP_SUB);
        upd_cf_c = 1'b1;
        upd_l_c  = 1'b1;
        c_c      = a_c < b_c;
        l_c      = a_c < b_c;
        f_c      = (a_c[WIDTH-1] != b_c[WIDTH-1]) && (result_c[WIDTH-1] != a_c[WIDTH-1]);
      end
      default: legal_c = 1'b0;
    endcase
  end

  // Write-back and flag update, qualified by the bus enable
  always_comb begin
    regs_d    = regs_q;
    flags_d   = flags_q;
    last_wr_d = last_wr_q;
    if (buff_en && legal_c) begin
      flags_d[FZ] = (result_c == '0);
      flags_d[FN] = result_c[WIDTH-1];
      if (upd_cf_c) begin
        flags_d[FC] = c_c;
        flags_d[FF] = f_c;
      end
      if (upd_l_c) flags_d[FL] = l_c;
      if (wr_ok_c) begin
        for (int unsigned i = 0; i < NREGS; i++) begin
          if (regs_en[i]) regs_d[i] = result_c;
        end
        if (|regs_en) last_wr_d = result_c;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < NREGS; i++) regs_q[i] <= '0;
      flags_q   <= '0;
      last_wr_q <= '0;
    end else begin
      regs_q    <= regs_d;
      flags_q   <= flags_d;
      last_wr_q <= last_wr_d;
    end
  end

  assign bus_out = buff_en ? result_c : '0;
  assign flags   = flags_q;
  assign last_wr = last_wr_q;

endmodule

// File: tb/tb_fsm_datapath.sv
// Scoreboard bench for fsm_datapath: driver pushes model predictions, monitor pops and compares.
`timescale 1ns/1ps
module tb_fsm_datapath;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  alu_op;
  logic [4:0]  muxA, muxB;
  logic [15:0] imm;
  logic        imm_control;
  logic [15:0] regs_en;
  logic        buff_en;
  logic [15:0] bus_out;
  logic [4:0]  flags;
  logic [15:0] last_wr;

  fsm_datapath #(.WIDTH(16), .NREGS(16)) dut (
    .clk(clk), .reset(reset), .alu_op(alu_op), .muxA(muxA), .muxB(muxB),
    .imm(imm), .imm_control(imm_control), .regs_en(regs_en), .buff_en(buff_en),
    .bus_out(bus_out), .flags(flags), .last_wr(last_wr)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0] bus;
    logic [4:0]  flg;
    logic [15:0] last;
  } exp_t;

  exp_t exp_q[$];
  int checks = 0;
  int errors = 0;

  // Reference state
  int unsigned m_regs [16];
  int unsigned m_last;
  bit mC, mL, mF, mZ, mN;

  function automatic int to_s(input int unsigned v);
    return (v >= 32768) ? int'(v) - 65536 : int'(v);
  endfunction

  task automatic check(input string name, input int unsigned act, input int unsigned req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, req, $time);
    end
  endtask

  task automatic model_reset();
    foreach (m_regs[i]) m_regs[i] = 0;
    m_last = 0;
    {mC, mL, mF, mZ, mN} = 5'b0;
  endtask

  task automatic model_step(input logic [7:0] op, input logic [4:0] ma, input logic [4:0] mb,
                            input logic [15:0] im, input logic ic, input logic [15:0] en,
                            input logic be, output logic [15:0] bus);
    int unsigned a, b, res, full;
    int sres;
    bit legal, arith, sub;
    a = (ma < 16) ? m_regs[ma] : 0;
    b = ic ? int'(im) : ((mb < 16) ? m_regs[mb] : 0);
    legal = 1; arith = 0; sub = 0; res = 0; full = 0; sres = 0;
    case (op)
      8'h01: res = a & b;
      8'h02: res = a | b;
      8'h03: res = a ^ b;
      8'h04: res = (a << (b % 16)) % 65536;
      8'h08: res = a >> (b % 16);
      8'h0D: res = b;
      8'h05, 8'h07: begin
        full  = a + b + ((op == 8'h07) ? int'(mC) : 0);
        res   = full % 65536;
        sres  = to_s(a) + to_s(b) + ((op == 8'h07) ? int'(mC) : 0);
        arith = 1;
      end
      8'h09, 8'h0B: begin
        res   = (a + 65536 - b) % 65536;
        sres  = to_s(a) - to_s(b);
        arith = 1; sub = 1;
      end
      default: legal = 0;
    endcase
    bus = be ? 16'(res) : 16'h0;
    if (be && legal) begin
      mZ = (res == 0);
      mN = (res >= 32768);
      if (arith) begin
        mC = sub ? (a < b) : (full > 65535);
        mF = (sres > 32767) || (sres < -32768);
      end
      if (sub) mL = (a < b);
      if (op != 8'h0B && en != 0) begin
        for (int i = 0; i < 16; i++) if (en[i]) m_regs[i] = res;
        m_last = res;
      end
    end
  endtask

  // Drive one control word on the falling edge and queue what it should produce
  task automatic do_op(input logic [7:0] op, input logic [4:0] ma, input logic [4:0] mb,
                       input logic [15:0] im, input logic ic, input logic [15:0] en, input logic be);
    exp_t e;
    @(negedge clk);
    alu_op = op; muxA = ma; muxB = mb; imm = im; imm_control = ic; regs_en = en; buff_en = be;
    model_step(op, ma, mb, im, ic, en, be, e.bus);
    e.flg  = {mC, mL, mF, mZ, mN};
    e.last = 16'(m_last);
    exp_q.push_back(e);
  endtask

  task automatic read_reg(input logic [4:0] r);
    do_op(8'h0D, 5'd0, r, 16'h0, 1'b0, 16'h0, 1'b1);
  endtask

  // Monitor: bus before the edge, registered state just after it
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("bus_out", bus_out, e.bus);
        @(posedge clk);
        #1;
        check("flags", flags, e.flg);
        check("last_wr", last_wr, e.last);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0] ops [11];
    ops = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h07, 8'h08, 8'h09, 8'h0B, 8'h0D, 8'h00};
    reset = 1'b1; alu_op = 8'h0; muxA = 5'd0; muxB = 5'd0; imm = 16'h0;
    imm_control = 1'b0; regs_en = 16'h0; buff_en = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    #1;
    check("reset_flags", flags, 5'b0);
    check("reset_last_wr", last_wr, 16'h0);
    check("reset_bus", bus_out, 16'h0);
    reset = 1'b0;

    repeat (3) do_op(8'h05, 5'd1, 5'd2, 16'h1, 1'b1, 16'hFFFF, 1'b0);
    for (int r = 0; r < 6; r++) read_reg(5'(r));

    // Fibonacci chain R1..R5
    do_op(8'h05, 5'd1, 5'd0, 16'h1, 1'b1, 16'h0002, 1'b1);
    do_op(8'h05, 5'd1, 5'd2, 16'h0, 1'b0, 16'h0004, 1'b1);
    do_op(8'h05, 5'd2, 5'd1, 16'h0, 1'b0, 16'h0008, 1'b1);
    do_op(8'h05, 5'd3, 5'd2, 16'h0, 1'b0, 16'h0010, 1'b1);
    do_op(8'h05, 5'd4, 5'd3, 16'h0, 1'b0, 16'h0020, 1'b1);
    for (int r = 1; r < 6; r++) read_reg(5'(r));

    // Async reset pulse between edges
    @(negedge clk);
    alu_op = 8'h05; buff_en = 1'b0; regs_en = 16'h0;
    #3 reset = 1'b1;
    #0.5;
    check("midreset_flags", flags, 5'b0);
    check("midreset_last_wr", last_wr, 16'h0);
    #0.5 reset = 1'b0;
    model_reset();
    do_op(8'h05, 5'd5, 5'd0, 16'h2, 1'b1, 16'h0040, 1'b1);
    read_reg(5'd6);
    read_reg(5'd5);

    // Carry chain
    do_op(8'h0D, 5'd0, 5'd0, 16'hFFFF, 1'b1, 16'h0002, 1'b1);
    do_op(8'h05, 5'd1, 5'd0, 16'h0001, 1'b1, 16'h0004, 1'b1);
    do_op(8'h07, 5'd0, 5'd0, 16'h0000, 1'b1, 16'h0008, 1'b1);
    read_reg(5'd3);

    // Compare does not write
    do_op(8'h0D, 5'd0, 5'd0, 16'h3, 1'b1, 16'h0002, 1'b1);
    do_op(8'h0D, 5'd0, 5'd0, 16'h5, 1'b1, 16'h0004, 1'b1);
    do_op(8'h0B, 5'd1, 5'd2, 16'h0, 1'b0, 16'h0008, 1'b1);
    read_reg(5'd3);

    // Signed overflow, then an illegal opcode
    do_op(8'h0D, 5'd0, 5'd0, 16'h7FFF, 1'b1, 16'h0010, 1'b1);
    do_op(8'h05, 5'd4, 5'd0, 16'h0001, 1'b1, 16'h0010, 1'b1);
    do_op(8'hFF, 5'd4, 5'd4, 16'h1234, 1'b1, 16'hFFFF, 1'b1);
    read_reg(5'd4);
    read_reg(5'd20);

    for (int n = 0; n < 400; n++) begin
      logic [7:0] op;
      op = ($urandom_range(0, 15) == 0) ? 8'($urandom) : ops[$urandom_range(0, 10)];
      do_op(op, 5'($urandom), 5'($urandom), 16'($urandom), 1'($urandom),
            ($urandom_range(0, 3) == 0) ? 16'h0 : 16'($urandom),
            ($urandom_range(0, 4) != 0));
    end

    repeat (3) @(negedge clk);
    check("queue_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
